// File: rtl/mul_seq_ctrl_pkg.sv
// Shared execute-stage types and sizes for the multi-cycle multiply sequencer.
package exec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_BITS_PER_CYCLE = 1;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH / MUL_BITS_PER_CYCLE);

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Issue/result bundle between the RegDec/Exec pipeline (master) and the multiply sequencer (slave).
interface mul_seq_ctrl_if
  import exec_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
);
  logic             issue;
  logic             flush;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic [4:0]       Rd_in;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       Rd_out;

  modport master (
    output issue, flush, DataA, DataB, Rd_in,
    input  stall, busy, done, result, Rd_out
  );

  modport slave (
    input  issue, flush, DataA, DataB, Rd_in,
    output stall, busy, done, result, Rd_out
  );
endinterface

// File: rtl/mul_seq_ctrl_step.sv
// One shift-add iteration: consumes BITS_PER_CYCLE multiplier bits, result truncated to WIDTH.
module mul_step #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0] o_mplier
);

  always_comb begin
    o_acc = i_acc;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (i_mplier[b]) o_acc = o_acc + (i_mcand << b);
    end
    o_mcand  = i_mcand << BITS_PER_CYCLE;
    o_mplier = i_mplier >> BITS_PER_CYCLE;
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle low-half multiply sequencer with pipeline stall handshake.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for an unflushed issue; stall follows issue combinationally
// BUSY  | one shift-add step per cycle, stall held
// DONE  | done pulse, result/Rd_out valid, pipeline advances
module mul_seq_ctrl
  import exec_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int BITS_PER_CYCLE = MUL_BITS_PER_CYCLE
) (
  input logic           clk,
  input logic           reset,
  mul_seq_ctrl_if.slave bus
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);

  mul_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier, r_result;
  logic [WIDTH-1:0] w_acc_nxt, w_mcand_nxt, w_mplier_nxt;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_last;
  logic             w_stall, w_busy, w_done;

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_nxt),
    .o_mcand  (w_mcand_nxt),
    .o_mplier (w_mplier_nxt)
  );

  assign w_accept = bus.issue && !bus.flush;

`ifdef MUL_EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_W'(N - 1)) || (w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CNT_W'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = BUSY;
      BUSY: begin
        if (bus.flush)   w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: w_stall = w_accept;
      BUSY: begin
        w_busy  = 1'b1;
        w_stall = !bus.flush;
      end
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // result is captured on the final step so it is already stable during DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
    end else if (r_state == IDLE && w_accept) begin
      r_acc    <= '0;
      r_mcand  <= bus.DataA;
      r_mplier <= bus.DataB;
      r_rd     <= bus.Rd_in;
      r_cnt    <= '0;
    end else if (r_state == BUSY && !bus.flush) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_result <= w_acc_nxt;
    end
  end

  assign bus.stall  = w_stall;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.Rd_out = r_rd;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: latency, stall window, truncation, back-to-back, flush and reset.
module tb_mul_seq_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  mul_seq_ctrl_if #(.WIDTH(64)) bus ();

  mul_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // BUSY cycles for a given multiplier at BITS_PER_CYCLE=1
  function automatic int exp_busy(input logic [63:0] b);
    int m;
    m = 0;
    for (int i = 0; i < 64; i++) if (b[i]) m = i + 1;
`ifdef MUL_EARLY_TERM_EN
    return (m == 0) ? 1 : m;
`else
    return 64;
`endif
  endfunction

  // Called at a negedge; exp_cyc is the number of posedges from now until done is seen
  task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp_r, input int exp_cyc, input int skip,
                        input bit keep);
    int cyc;
    bit stall_bad;
    bus.issue = 1'b1;
    bus.flush = 1'b0;
    bus.DataA = a;
    bus.DataB = b;
    bus.Rd_in = rd;
    cyc = 0;
    stall_bad = 1'b0;
    #1;
    while (!(bus.done && cyc > 0) && cyc < 300) begin
      if (cyc >= skip && !bus.stall) stall_bad = 1'b1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("latency", 64'(cyc), 64'(exp_cyc));
    chk("stall_window", {63'd0, stall_bad}, 64'd0);
    chk("result", bus.result, exp_r);
    chk("rd_out", {59'd0, bus.Rd_out}, {59'd0, rd});
    chk("stall_in_done", {63'd0, bus.stall}, 64'd0);
    if (!keep) begin
      @(posedge clk);
      #1 bus.issue = 1'b0;
      @(negedge clk);
      chk("no_restart_busy", {63'd0, bus.busy}, 64'd0);
      chk("no_restart_done", {63'd0, bus.done}, 64'd0);
    end
  endtask

  initial begin
    bit late_done;
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus.issue = 1'b0;
    bus.flush = 1'b0;
    bus.DataA = '0;
    bus.DataB = '0;
    bus.Rd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_rd", {59'd0, bus.Rd_out}, 64'd0);
    reset = 1'b0;

    // issue with flush in IDLE is not accepted
    @(negedge clk);
    bus.issue = 1'b1;
    bus.flush = 1'b1;
    bus.DataA = 64'd8;
    bus.DataB = 64'd8;
    #1 chk("idle_flush_stall", {63'd0, bus.stall}, 64'd0);
    @(negedge clk);
    chk("idle_flush_busy", {63'd0, bus.busy}, 64'd0);
    bus.issue = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);

    do_mul(64'd3, 64'd5, 5'd7, 64'd15, exp_busy(64'd5) + 1, 0, 1'b0);
    do_mul(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd12, 64'hFFFF_FFFF_FFFF_FFEB,
           exp_busy(64'd7) + 1, 0, 1'b0);
    do_mul(64'h8000_0000_0000_0000, 64'd2, 5'd31, 64'd0, exp_busy(64'd2) + 1, 0, 1'b0);

    // back-to-back: second MUL presented during the first one's DONE cycle
    do_mul(64'd6, 64'd7, 5'd3, 64'd42, exp_busy(64'd7) + 1, 0, 1'b1);
    do_mul(64'h1_0000_0000, 64'h1_0000_0000, 5'd4, 64'd0,
           exp_busy(64'h1_0000_0000) + 2, 1, 1'b0);

    // flush mid-BUSY at cycle 10, fresh issue at cycle 11
    bus.issue = 1'b1;
    bus.DataA = 64'd9;
    bus.DataB = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.Rd_in = 5'd1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    #1 chk("flush_stall_drop", {63'd0, bus.stall}, 64'd0);
    chk("flush_cycle_busy", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("post_flush_busy", {63'd0, bus.busy}, 64'd0);
    chk("post_flush_done", {63'd0, bus.done}, 64'd0);
    do_mul(64'd5, 64'd11, 5'd2, 64'd55, exp_busy(64'd11) + 1, 0, 1'b0);

    // flush during DONE leaves the committed result alone
    do_mul(64'd4, 64'd4, 5'd6, 64'd16, exp_busy(64'd4) + 1, 0, 1'b1);
    bus.flush = 1'b1;
    #1 chk("done_flush_done", {63'd0, bus.done}, 64'd1);
    @(posedge clk);
    #1 bus.issue = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("done_flush_result", bus.result, 64'd16);
    chk("done_flush_busy", {63'd0, bus.busy}, 64'd0);

    // reset pulse at cycle 20 of a multiply
    bus.issue = 1'b1;
    bus.DataA = 64'd10;
    bus.DataB = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.Rd_in = 5'd8;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.issue = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_stall", {63'd0, bus.stall}, 64'd0);
    chk("midrst_result", bus.result, 64'd0);
    chk("midrst_rd", {59'd0, bus.Rd_out}, 64'd0);
    late_done = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.done) late_done = 1'b1;
    end
    chk("midrst_no_done", {63'd0, late_done}, 64'd0);
    do_mul(64'd12, 64'd12, 5'd9, 64'd144, exp_busy(64'd12) + 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
